// File: rtl/down_count_monitor_pkg.sv
// Shared definitions for the down-counter monitor: FSM state encoding and
// default widths that also size the companion down counter.
package down_count_monitor_pkg;

    localparam int DCM_WIDTH  = 4;
    localparam int DCM_WRAP_W = 4;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } dcm_state_e;

endpackage

// File: rtl/down_count_monitor_if.sv
// Bundle of the monitor's sample inputs and event outputs, with one modport
// for the monitor itself and one for the logic driving/consuming it.
interface down_count_monitor_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 4
);
    logic              en;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  cmp;
    logic              tc;
    logic              match;
    logic [WRAP_W-1:0] wraps;
    logic              wraps_ovf;
    logic              err;

    modport mon (
        input  en, cnt, cmp,
        output tc, match, wraps, wraps_ovf, err
    );

    modport ctrl (
        output en, cnt, cmp,
        input  tc, match, wraps, wraps_ovf, err
    );
endinterface

// File: rtl/down_count_monitor_wrap_counter.sv
// Enabled WRAP_W-bit incrementer with a sticky flag set when the count
// rolls over from all-ones to zero.
module wrap_counter #(
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              inc_i,
    output logic [WRAP_W-1:0] count_o,
    output logic              ovf_o
);

    logic [WRAP_W-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc_i) begin
            count_d = count_q + WRAP_W'(1);
            ovf_d   = ovf_q | (&count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/down_count_monitor.sv
// Checks that each enabled sample of a down counter is the previous one minus
// one, pulses tc on the 0->max wrap, counts wraps and flags compare matches.
module down_count_monitor
    import down_count_monitor_pkg::*;
#(
    parameter int WIDTH  = DCM_WIDTH,
    parameter int WRAP_W = DCM_WRAP_W
) (
    input  logic              clk,
    input  logic              set,
    input  logic              en,
    input  logic [WIDTH-1:0]  cnt,
    input  logic [WIDTH-1:0]  cmp,
    output logic              tc,
    output logic              match,
    output logic [WRAP_W-1:0] wraps,
    output logic              wraps_ovf,
    output logic              err
);

    dcm_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             tc_q, tc_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             wrap_inc;
    logic [WIDTH-1:0] exp_val;

    assign exp_val = prev_q - WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        tc_d     = 1'b0;
        match_d  = 1'b0;
        err_d    = err_q;
        wrap_inc = 1'b0;
        if (en) begin
            match_d = (cnt == cmp);
            prev_d  = cnt;
            unique case (state_q)
                // First sample after reset only seeds the history.
                ST_INIT: state_d = ST_TRACK;
                ST_TRACK: begin
                    if (cnt == exp_val) begin
                        if (prev_q == '0) begin
                            tc_d     = 1'b1;
                            wrap_inc = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (set) begin
            state_q <= ST_INIT;
            prev_q  <= '0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            tc_q    <= tc_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    wrap_counter #(
        .WRAP_W (WRAP_W)
    ) u_wrap_counter (
        .clk     (clk),
        .srst    (set),
        .inc_i   (wrap_inc),
        .count_o (wraps),
        .ovf_o   (wraps_ovf)
    );

    assign tc    = tc_q;
    assign match = match_q;
    assign err   = err_q;

endmodule

// File: doc/down_count_monitor.md
# down_count_monitor

Downstream checker for the 4-bit synchronous down counter. It samples the counter output every enabled cycle and verifies that each value is the previous one minus 1, modulo 2^WIDTH. It emits a terminal-count pulse on each 0→max wrap, counts those wraps, and flags a programmable compare match. A sticky error is raised on any broken sequence. It sits on the counter's `o` bus, between the counter and the control logic that consumes its events.

## Interface
Parameters:
- `WIDTH`, 4: width of the sampled count.
- `WRAP_W`, 4: width of the wrap counter.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `set`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: sample-enable; `cnt` is observed only when high.
- `cnt`, input, WIDTH: count value from the down counter.
- `cmp`, input, WIDTH: compare value for `match`.
- `tc`, output, 1: one-cycle pulse on a legal 0→(2^WIDTH−1) transition.
- `match`, output, 1: one-cycle pulse when a sampled `cnt` equals `cmp`.
- `wraps`, output, WRAP_W: number of `tc` events, modulo 2^WRAP_W.
- `wraps_ovf`, output, 1: sticky; set when `wraps` rolls from max to 0.
- `err`, output, 1: sticky; set on the first sequence violation.

## Operation
- Internal registers:
  - `prev`, WIDTH bits: last sampled value.
  - `state`: one of INIT, TRACK, FAULT.
- `set` = 1 (highest priority, overrides `en`):
  - `state` ← INIT, `prev` ← 0.
  - `tc`, `match`, `wraps`, `wraps_ovf`, `err` all ← 0.
- `en` = 0:
  - All registers hold; `tc` and `match` ← 0.
  - Disabled cycles are invisible to the sequence check.
- `en` = 1, state INIT:
  - `prev` ← `cnt`, go to TRACK.
  - No check; no `tc`, even if `cnt` = max.
- `en` = 1, state TRACK, expected value `exp` = (`prev` − 1) mod 2^WIDTH:
  - `cnt` == `exp`: `prev` ← `cnt`.
    - If `prev` == 0, the transition is a wrap: `tc` ← 1 and `wraps` ← `wraps` + 1.
    - If `wraps` was max at that point, `wraps_ovf` ← 1.
  - `cnt` != `exp`: `err` ← 1, `prev` ← `cnt`, go to FAULT. No `tc` this cycle.
- `en` = 1, state FAULT:
  - `prev` ← `cnt`; `tc` stays 0; `wraps` is frozen; `err` stays 1.
  - Leaves FAULT only through `set`.
- `match`: `match` ← `en` & (`cnt` == `cmp`), in every state except during `set`.
- All subtraction wraps modulo 2^WIDTH. `wraps` wraps modulo 2^WRAP_W.
- Sticky flags never clear except by `set`.

## Timing
- All outputs are registered: one cycle of latency from the `cnt` sample edge to `tc`, `match`, `err`, `wraps`.
- `tc` and `match` are exactly one cycle wide per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- Reset mid-run: the cycle after `set` shows every output at 0. The first enabled sample after `set` is never flagged.
- Simultaneous events: `tc` and `match` can both assert in the same cycle (for example `cmp` = max at the wrap).
- A wrap and a violation cannot coincide; a violation always suppresses `tc`.

## Structure
- Shared package holds:
  - the state enum (INIT, TRACK, FAULT);
  - default `WIDTH` and `WRAP_W` constants, shared with the down counter.
- One natural sub-module, `wrap_counter`: an enabled WRAP_W-bit incrementer with a sticky overflow flag, instantiated once.
- The sequence check and FSM stay in the top module.

## Test plan
- Reset, then `en` = 1 with `cnt` = 5, 4, 3, 2, 1, 0, 15, 14 → `tc` pulses once, one cycle after the 15 sample; `wraps` = 1; `err` = 0.
- `en` = 1 with `cnt` = 9, 8, 6 → `err` = 1 one cycle after the 6 sample, state FAULT. A following legal 0→15 gives no `tc`, and `err` stays 1 until `set`.
- `cmp` = 15, then `cnt` = 1, 0, 15 → `tc` and `match` assert together, for one cycle.
- Sixteen full down cycles (0→15 sixteen times, `WRAP_W` = 4) → `wraps` returns to 0 and `wraps_ovf` = 1 (sticky). A 17th wrap gives `wraps` = 1 with `wraps_ovf` still 1.
- `cnt` = 7, then `en` = 0 for 3 cycles while `cnt` shows 3, then `en` = 1 with `cnt` = 6 → no `err`; `tc` and `match` stay 0 during the gap.
- Assert `set` mid-run with `en` = 1 and `cnt` = 0 → next cycle all outputs are 0 and the state is INIT. A following sample `cnt` = 15 is accepted without `tc` and without `err`.
